// File: rtl/scoot_bot_fsm.sv
// scoot_bot_fsm: sequential controller for the four-actuator scoot platform.
// Debounces each raw sensor channel, then runs a timed
// forward / back-up / turn behaviour with registered actuator outputs.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   enable     run request; low forces IDLE
//   sensors    raw obstacle sensors, 1 = obstacle
//   drive_fwd  forward motor command
//   drive_rev  reverse motor command
//   turn_left  left turn command
//   turn_right right turn command
//   state      current FSM state (IDLE=0 FWD=1 BACKUP=2 TURN=3 STALL=4)
//   bump_count saturating count of obstacle events
//   stalled    high while in STALL
//
// Optional feature macro: SCOOT_STALL_DETECT_EN
//   When defined, a TURN that ends with an obstacle still present is
//   retried; a fourth consecutive blocked exit parks the bot in STALL.
//   When undefined, TURN always returns to FWD and stalled is tied to 0.

module scoot_bot_fsm #(
    parameter int NUM_SENSORS   = 5,
    parameter int DEB_CYCLES    = 4,
    parameter int BACKUP_CYCLES = 8,
    parameter int TURN_CYCLES   = 6,
    parameter int CNT_W         = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [NUM_SENSORS-1:0] sensors,
    output logic                   drive_fwd,
    output logic                   drive_rev,
    output logic                   turn_left,
    output logic                   turn_right,
    output logic [2:0]             state,
    output logic [7:0]             bump_count,
    output logic                   stalled
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FWD    = 3'd1;
    localparam logic [2:0] S_BACKUP = 3'd2;
    localparam logic [2:0] S_TURN   = 3'd3;
    localparam logic [2:0] S_STALL  = 3'd4;

    localparam int LEFT_W = NUM_SENSORS / 2;

    localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] BACKUP_LAST = CNT_W'(BACKUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TURN_LAST   = CNT_W'(TURN_CYCLES - 1);

    // ---------------- debounce ----------------
    logic [NUM_SENSORS-1:0] filt_q, filt_d;
    logic [CNT_W-1:0]       deb_cnt_q [NUM_SENSORS];
    logic [CNT_W-1:0]       deb_cnt_d [NUM_SENSORS];

    // The counter value DEB_LAST on a mismatching cycle means this is the
    // DEB_CYCLES-th consecutive differing sample, so the filter flips now.
    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < NUM_SENSORS; i++) begin
            deb_cnt_d[i] = '0;
            if (sensors[i] != filt_q[i]) begin
                if (deb_cnt_q[i] == DEB_LAST) begin
                    filt_d[i] = sensors[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    logic obs_left, obs_right, obstacle;

    assign obs_left  = |filt_q[LEFT_W-1:0];
    assign obs_right = |filt_q[NUM_SENSORS-1:LEFT_W];
    assign obstacle  = obs_left | obs_right;

    // ---------------- behaviour FSM ----------------
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             turn_dir_q, turn_dir_d;   // 1 = right
    logic [7:0]       bump_q, bump_d;
`ifdef SCOOT_STALL_DETECT_EN
    logic [1:0]       retry_q, retry_d;
`endif

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        turn_dir_d = turn_dir_q;
        bump_d     = bump_q;
`ifdef SCOOT_STALL_DETECT_EN
        retry_d    = retry_q;
`endif
        if (!enable) begin
            state_d    = S_IDLE;
            timer_d    = '0;
            turn_dir_d = 1'b0;
`ifdef SCOOT_STALL_DETECT_EN
            retry_d    = '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_FWD;
                end
                S_FWD: begin
                    if (obstacle) begin
                        state_d    = S_BACKUP;
                        timer_d    = BACKUP_LAST;
                        // Obstacle on the left (or both sides): turn right.
                        turn_dir_d = obs_left;
                        if (bump_q != 8'hFF) begin
                            bump_d = bump_q + 8'd1;
                        end
                    end
                end
                S_BACKUP: begin
                    if (timer_q == '0) begin
                        state_d = S_TURN;
                        timer_d = TURN_LAST;
                    end else begin
                        timer_d = timer_q - CNT_W'(1);
                    end
                end
                S_TURN: begin
                    if (timer_q == '0) begin
`ifdef SCOOT_STALL_DETECT_EN
                        if (obstacle) begin
                            if (retry_q == 2'd3) begin
                                state_d = S_STALL;
                            end else begin
                                timer_d = TURN_LAST;
                                retry_d = retry_q + 2'd1;
                            end
                        end else begin
                            state_d = S_FWD;
                            retry_d = '0;
                        end
`else
                        state_d = S_FWD;
`endif
                    end else begin
                        timer_d = timer_q - CNT_W'(1);
                    end
                end
                S_STALL: begin
                    state_d = S_STALL;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Actuators are decoded from the next state so they are registered
    // alongside it and match state after every edge.
    logic fwd_d, rev_d, tl_d, tr_d, stall_d;
    logic fwd_q, rev_q, tl_q, tr_q, stall_q;

    always_comb begin
        fwd_d   = (state_d == S_FWD);
        rev_d   = (state_d == S_BACKUP);
        tl_d    = (state_d == S_TURN) && !turn_dir_d;
        tr_d    = (state_d == S_TURN) && turn_dir_d;
        stall_d = (state_d == S_STALL);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            filt_q     <= '0;
            for (int i = 0; i < NUM_SENSORS; i++) begin
                deb_cnt_q[i] <= '0;
            end
            state_q    <= S_IDLE;
            timer_q    <= '0;
            turn_dir_q <= 1'b0;
            bump_q     <= '0;
`ifdef SCOOT_STALL_DETECT_EN
            retry_q    <= '0;
`endif
            fwd_q      <= 1'b0;
            rev_q      <= 1'b0;
            tl_q       <= 1'b0;
            tr_q       <= 1'b0;
            stall_q    <= 1'b0;
        end else begin
            filt_q     <= filt_d;
            for (int i = 0; i < NUM_SENSORS; i++) begin
                deb_cnt_q[i] <= deb_cnt_d[i];
            end
            state_q    <= state_d;
            timer_q    <= timer_d;
            turn_dir_q <= turn_dir_d;
            bump_q     <= bump_d;
`ifdef SCOOT_STALL_DETECT_EN
            retry_q    <= retry_d;
`endif
            fwd_q      <= fwd_d;
            rev_q      <= rev_d;
            tl_q       <= tl_d;
            tr_q       <= tr_d;
            stall_q    <= stall_d;
        end
    end

    assign drive_fwd  = fwd_q;
    assign drive_rev  = rev_q;
    assign turn_left  = tl_q;
    assign turn_right = tr_q;
    assign state      = state_q;
    assign bump_count = bump_q;
`ifdef SCOOT_STALL_DETECT_EN
    assign stalled    = stall_q;
`else
    assign stalled    = 1'b0;
`endif

endmodule

// File: tb/tb_scoot_bot_fsm.sv
// Self-checking bench for scoot_bot_fsm (default parameters).
// Driver queues hand-computed expectations; a negedge monitor checks them.

module tb_scoot_bot_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [4:0] sensors;
    logic       drive_fwd, drive_rev, turn_left, turn_right;
    logic [2:0] state;
    logic [7:0] bump_count;
    logic       stalled;

    scoot_bot_fsm dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .sensors    (sensors),
        .drive_fwd  (drive_fwd),
        .drive_rev  (drive_rev),
        .turn_left  (turn_left),
        .turn_right (turn_right),
        .state      (state),
        .bump_count (bump_count),
        .stalled    (stalled)
    );

    always #5 clk = ~clk;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_FWD  = 3'd1;
    localparam logic [2:0] S_BK   = 3'd2;
    localparam logic [2:0] S_TURN = 3'd3;
    localparam logic [2:0] S_STL  = 3'd4;

    // {drive_fwd, drive_rev, turn_left, turn_right}
    localparam logic [3:0] A_NONE = 4'b0000;
    localparam logic [3:0] A_FWD  = 4'b1000;
    localparam logic [3:0] A_REV  = 4'b0100;
    localparam logic [3:0] A_TL   = 4'b0010;
    localparam logic [3:0] A_TR   = 4'b0001;

    typedef struct {
        string      name;
        logic [2:0] st;
        logic [3:0] act;
        logic [7:0] bump;
        logic       stl;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   total = 0;
    int   bad   = 0;
    logic [3:0] act_now;

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            e = sb.pop_front();
            act_now = {drive_fwd, drive_rev, turn_left, turn_right};
            total++;
            if (state !== e.st || act_now !== e.act ||
                bump_count !== e.bump || stalled !== e.stl) begin
                bad++;
                $display("FAIL %s t=%0t got st=%0d act=%b bump=%0d stl=%b want st=%0d act=%b bump=%0d stl=%b",
                         e.name, $time, state, act_now, bump_count, stalled,
                         e.st, e.act, e.bump, e.stl);
            end
        end
    end

    task automatic run(input string nm, input int n,
                       input logic r, input logic en,
                       input logic [4:0] s,
                       input logic [2:0] st, input logic [3:0] act,
                       input logic [7:0] bmp, input logic stl);
        for (int i = 0; i < n; i++) begin
            reset   = r;
            enable  = en;
            sensors = s;
            @(posedge clk);
            sb.push_back('{nm, st, act, bmp, stl});
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        enable  = 1'b0;
        sensors = '0;

        run("reset",   2, 1, 0, 5'b00000, S_IDLE, A_NONE, 8'd0, 0);
        run("enable",  1, 0, 1, 5'b00000, S_FWD,  A_FWD,  8'd0, 0);

        // left-group obstacle: debounce 4, backup 8, turn right 6
        run("deb_l",   4, 0, 1, 5'b00001, S_FWD,  A_FWD,  8'd0, 0);
        run("bk_l",    1, 0, 1, 5'b00001, S_BK,   A_REV,  8'd1, 0);
        run("bk_l",    7, 0, 1, 5'b00000, S_BK,   A_REV,  8'd1, 0);
        run("turn_r",  6, 0, 1, 5'b00000, S_TURN, A_TR,   8'd1, 0);
        run("fwd_l",   1, 0, 1, 5'b00000, S_FWD,  A_FWD,  8'd1, 0);

        // 3-cycle glitch is filtered out
        run("glitch",  3, 0, 1, 5'b10000, S_FWD,  A_FWD,  8'd1, 0);
        run("glitch",  5, 0, 1, 5'b00000, S_FWD,  A_FWD,  8'd1, 0);

        // right-group obstacle: turn left
        run("deb_r",   4, 0, 1, 5'b00100, S_FWD,  A_FWD,  8'd1, 0);
        run("bk_r",    1, 0, 1, 5'b00100, S_BK,   A_REV,  8'd2, 0);
        run("bk_r",    7, 0, 1, 5'b00000, S_BK,   A_REV,  8'd2, 0);
        run("turn_l",  6, 0, 1, 5'b00000, S_TURN, A_TL,   8'd2, 0);
        run("fwd_r",   1, 0, 1, 5'b00000, S_FWD,  A_FWD,  8'd2, 0);

        // enable dropped during 3rd BACKUP cycle
        run("deb_e",   4, 0, 1, 5'b00001, S_FWD,  A_FWD,  8'd2, 0);
        run("bk_e",    1, 0, 1, 5'b00001, S_BK,   A_REV,  8'd3, 0);
        run("bk_e",    2, 0, 1, 5'b00000, S_BK,   A_REV,  8'd3, 0);
        run("en_off",  3, 0, 0, 5'b00000, S_IDLE, A_NONE, 8'd3, 0);
        run("en_on",   1, 0, 1, 5'b00000, S_FWD,  A_FWD,  8'd3, 0);

        // reset in the middle of TURN
        run("deb_x",   4, 0, 1, 5'b00100, S_FWD,  A_FWD,  8'd3, 0);
        run("bk_x",    1, 0, 1, 5'b00100, S_BK,   A_REV,  8'd4, 0);
        run("bk_x",    7, 0, 1, 5'b00000, S_BK,   A_REV,  8'd4, 0);
        run("turn_x",  2, 0, 1, 5'b00000, S_TURN, A_TL,   8'd4, 0);
        run("rst_mid", 1, 1, 1, 5'b00000, S_IDLE, A_NONE, 8'd0, 0);
        run("idle",    1, 0, 0, 5'b00000, S_IDLE, A_NONE, 8'd0, 0);

        // obstacle held permanently
        run("en_h",    1, 0, 1, 5'b00000, S_FWD,  A_FWD,  8'd0, 0);
        run("deb_h",   4, 0, 1, 5'b00001, S_FWD,  A_FWD,  8'd0, 0);
        run("bk_h",    8, 0, 1, 5'b00001, S_BK,   A_REV,  8'd1, 0);
`ifdef SCOOT_STALL_DETECT_EN
        run("turn_h", 24, 0, 1, 5'b00001, S_TURN, A_TR,   8'd1, 0);
        run("stall",   3, 0, 1, 5'b00001, S_STL,  A_NONE, 8'd1, 1);
        run("stl_off", 2, 0, 0, 5'b00001, S_IDLE, A_NONE, 8'd1, 0);
`else
        run("turn_h",  6, 0, 1, 5'b00001, S_TURN, A_TR,   8'd1, 0);
        run("refwd1",  1, 0, 1, 5'b00001, S_FWD,  A_FWD,  8'd1, 0);
        run("bk_h2",   8, 0, 1, 5'b00001, S_BK,   A_REV,  8'd2, 0);
        run("turn_h2", 6, 0, 1, 5'b00001, S_TURN, A_TR,   8'd2, 0);
        run("refwd2",  1, 0, 1, 5'b00001, S_FWD,  A_FWD,  8'd2, 0);
        run("bk_h3",   1, 0, 1, 5'b00001, S_BK,   A_REV,  8'd3, 0);
        run("h_off",   2, 0, 0, 5'b00001, S_IDLE, A_NONE, 8'd3, 0);
`endif

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
